count_sequencer: RTL
====================

// Module: count_sequencer
// PURPOSE
//  Controller that runs programmed count jobs on the team's 4-bit up/down load counter.
//  Drives the counter's Load/In/Up/Down inputs and watches its Out output.
//  A job is: load StartVal, step toward EndVal in one direction, repeat for Repeats+1 passes.
//  Start/Busy/Done handshake to the host; supports Hold (pause) and Abort.
// PARAMETERS
//  WIDTH  4  counter width; must match the sequenced counter
//  REP_W  4  width of Repeats and PassCount
// PORTS
//  Clock      in   1      single clock, all state on rising edge
//  Reset      in   1      synchronous, active-low
//  Start      in   1      job request; sampled in IDLE only
//  StartVal   in   WIDTH  value loaded at start of each pass
//  EndVal     in   WIDTH  terminal value of each pass
//  Dir        in   1      1 = count up, 0 = count down
//  Repeats    in   REP_W  extra passes (total passes = Repeats+1)
//  Hold       in   1      pause stepping while high
//  Abort      in   1      cancel job, return to IDLE
//  CntOut     in   WIDTH  counter Out feedback
//  CntLoad    out  1      counter Load strobe
//  CntIn      out  WIDTH  counter In (latched StartVal)
//  CntUp      out  1      counter Up strobe
//  CntDown    out  1      counter Down strobe
//  Busy       out  1      high in LOAD, RUN, NEXT
//  Done       out  1      one-cycle pulse at normal job completion
//  PassCount  out  REP_W  passes completed in current/last job
// BEHAVIOUR
//  Reset (Reset=0 at edge): state=IDLE, PassCount=0, latched job regs=0; all outputs 0.
//  Reset mid-job overrides everything; counter is not touched afterwards.
//  States: IDLE -> LOAD -> RUN -> NEXT -> (LOAD | DONE) -> IDLE.
//  IDLE: Start=1 latches StartVal/EndVal/Dir/Repeats, clears PassCount, -> LOAD.
//    Inputs are not re-sampled during a job.
//  LOAD: CntLoad=1, CntIn=latched StartVal for exactly 1 cycle; -> RUN.
//  RUN: CntOut==EndVal -> NEXT, no strobe this cycle.
//    Otherwise, with Hold=0: CntUp=Dir, CntDown=~Dir. With Hold=1: no strobe, stay in RUN.
//  NEXT: PassCount+1. If new PassCount==Repeats+1 -> DONE, else -> LOAD.
//  DONE: Done=1, Busy=0 for 1 cycle; -> IDLE. Start in DONE is ignored.
//  Strobes are combinational from state, CntOut, Hold and Abort; never more than one of
//    CntLoad/CntUp/CntDown is high.
//  Distance D = (EndVal-StartVal) mod 2^WIDTH for up, (StartVal-EndVal) mod 2^WIDTH for down.
//    Wrap through 15->0 or 0->15 is legal. StartVal==EndVal gives D=0 (no strobes).
//  Pass timing: LOAD 1 + RUN D+1 + NEXT 1 + held cycles. Done is in the cycle after the final NEXT.
//  Abort=1 in any non-IDLE state: all strobes 0 this cycle, -> IDLE, no Done, PassCount kept.
//    Abort has priority over Hold and completion; Abort in IDLE has no effect.
// CONFIGURATION
//  COUNT_SEQ_BOUNCE_EN defined: NEXT goes directly to RUN (no LOAD) for every pass after
//    the first. Direction inverts and StartVal/EndVal swap each pass, so the counter
//    ping-pongs between the two values.
//  Undefined: every pass reloads StartVal and counts in the same direction.
// TESTING (bench instantiates the real counter with Out->CntOut)
//  Start=1 at cycle 0, StartVal=3, EndVal=7, Dir=1, Repeats=0 -> CntLoad/CntIn=3 at cycle 1;
//    CntUp at cycles 2-5; NEXT at cycle 7; Done pulse at cycle 8; PassCount=1.
//  StartVal=14, EndVal=1, Dir=1 -> 3 CntUp strobes; counter reads 14,15,0,1; Done.
//  StartVal=5, EndVal=2, Dir=0, Repeats=2 -> 3 LOADs, 9 CntDown strobes; PassCount=3 at Done.
//  Hold=1 for 2 cycles mid-RUN of case 1 -> no strobes while held; Done at cycle 10.
//  Abort=1 mid-RUN -> strobes 0 that cycle, IDLE next, no Done. Separately, Reset=0 mid-RUN ->
//    all outputs 0 after that edge. StartVal=EndVal=9 -> 0 strobes, Done at cycle 4.
//  COUNT_SEQ_BOUNCE_EN, StartVal=3, EndVal=7, Dir=1, Repeats=1 -> 1 LOAD, 4 CntUp then
//    4 CntDown, counter ends at 3, Done.

Source files
------------

// File: rtl/count_sequencer_if.sv
// count_sequencer_if: host job controls/status plus the counter drive/feedback lines.
// Latency: none, wiring only.
// Backpressure: none here; hold/abort are carried as plain levels.
interface count_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
);
    logic             start;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] end_val;
    logic             dir;
    logic [REP_W-1:0] repeats;
    logic             hold;
    logic             abort;
    logic [WIDTH-1:0] cnt_out;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_up;
    logic             cnt_down;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] pass_count;

    modport master (
        output start, start_val, end_val, dir, repeats, hold, abort, cnt_out,
        input  cnt_load, cnt_in, cnt_up, cnt_down, busy, done, pass_count
    );

    modport slave (
        input  start, start_val, end_val, dir, repeats, hold, abort, cnt_out,
        output cnt_load, cnt_in, cnt_up, cnt_down, busy, done, pass_count
    );
endinterface

// File: rtl/count_sequencer.sv
// count_sequencer: runs load/step/repeat jobs on the 4-bit up/down load counter (COUNT_SEQ_BOUNCE_EN = ping-pong passes).
// Latency: per pass LOAD 1 + RUN D+1 + NEXT 1 (+held cycles); Done pulses the cycle after the final NEXT.
// Backpressure: hold freezes stepping in RUN; abort drops to IDLE from any active state without Done.
module count_sequencer #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    count_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sv_q, sv_nx;
    logic [WIDTH-1:0] ev_q, ev_nx;
    logic             dir_q, dir_nx;
    logic [REP_W-1:0] rep_q, rep_nx;
    logic [REP_W-1:0] pass_q, pass_nx;
    logic             load, up, down, busy, done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sv_q   <= '0;
            ev_q   <= '0;
            dir_q  <= 1'b0;
            rep_q  <= '0;
            pass_q <= '0;
        end else begin
            state  <= state_nx;
            sv_q   <= sv_nx;
            ev_q   <= ev_nx;
            dir_q  <= dir_nx;
            rep_q  <= rep_nx;
            pass_q <= pass_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sv_nx    = sv_q;
        ev_nx    = ev_q;
        dir_nx   = dir_q;
        rep_nx   = rep_q;
        pass_nx  = pass_q;
        load     = 1'b0;
        up       = 1'b0;
        down     = 1'b0;
        done     = 1'b0;
        busy     = (state == LOAD) || (state == RUN) || (state == NEXT);

        // Abort outranks hold and completion; strobes stay low in the abort cycle.
        if (bus.abort && (state != IDLE)) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sv_nx    = bus.start_val;
                        ev_nx    = bus.end_val;
                        dir_nx   = bus.dir;
                        rep_nx   = bus.repeats;
                        pass_nx  = '0;
                        state_nx = LOAD;
                    end
                end
                LOAD: begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
                RUN: begin
                    if (bus.cnt_out == ev_q) begin
                        state_nx = NEXT;
                    end else if (!bus.hold) begin
                        up   = dir_q;
                        down = ~dir_q;
                    end
                end
                NEXT: begin
                    pass_nx = pass_q + REP_W'(1);
                    // pass_q == rep_q means the incremented count reaches repeats+1.
                    if (pass_q == rep_q) begin
                        state_nx = DONE;
                    end else begin
`ifdef COUNT_SEQ_BOUNCE_EN
                        sv_nx    = ev_q;
                        ev_nx    = sv_q;
                        dir_nx   = ~dir_q;
                        state_nx = RUN;
`else
                        state_nx = LOAD;
`endif
                    end
                end
                DONE: begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign bus.cnt_load   = load;
    assign bus.cnt_in     = sv_q;
    assign bus.cnt_up     = up;
    assign bus.cnt_down   = down;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.pass_count = pass_q;

endmodule
